// File: rtl/pxie_c2h_rd_sched_if.sv
// Signal bundle for pxie_c2h_rd_sched: read request, shared RAM read port,
// C2H transmit stream and transfer status.
interface pxie_c2h_rd_sched_if;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 128;

  logic [AW-1:0] I_c2h_addr;
  logic [AW-1:0] I_c2h_len;
  logic          I_c2h_en;
  logic          I_sys_wren;
  logic [AW-1:0] O_ram_addr;
  logic          O_ram_rden;
  logic [DW-1:0] I_ram_rdata;
  logic [DW-1:0] O_tx_data;
  logic          O_tx_vld;
  logic          I_tx_rdy;
  logic          O_tx_last;
  logic          O_busy;
  logic          O_done;
  logic          O_c2h_drop;

  modport master (
    output I_c2h_addr, I_c2h_len, I_c2h_en, I_sys_wren, I_ram_rdata, I_tx_rdy,
    input  O_ram_addr, O_ram_rden, O_tx_data, O_tx_vld, O_tx_last,
           O_busy, O_done, O_c2h_drop
  );

  modport slave (
    input  I_c2h_addr, I_c2h_len, I_c2h_en, I_sys_wren, I_ram_rdata, I_tx_rdy,
    output O_ram_addr, O_ram_rden, O_tx_data, O_tx_vld, O_tx_last,
           O_busy, O_done, O_c2h_drop
  );
endinterface

// File: rtl/pxie_c2h_rd_sched.sv
// Card-to-host read scheduler: reads a word range from shared RAM (yielding to
// host writes) into a credit-limited FWFT FIFO feeding the C2H stream.
// Optional header beat enabled by defining PXIE_C2H_HEADER_EN.
module pxie_c2h_rd_sched #(
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               I_PXIE_CLK,
  input  logic               I_Rst_n,
  pxie_c2h_rd_sched_if.slave bus
);
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 128;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
`ifdef PXIE_C2H_HEADER_EN
    ST_HDR,
`endif
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   cur_addr_q;
  logic [AW-1:0]   rem_q;
  logic [AW-1:0]   len_q;
  logic [AW-1:0]   sent_q;
  logic [CW-1:0]   inflight_q;
  logic [CW-1:0]   fifo_cnt_q;
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [RD_LAT-1:0] rd_sr_q;
  logic [DW-1:0]   mem [FIFO_DEPTH];

  logic accept_c;
  logic issue_c;
  logic hdr_vld_c;
  logic push_c;
  logic pop_c;
  logic fifo_vld_c;
  logic last_c;
  logic credit_ok_c;

  // A word leaves the read pipe RD_LAT cycles after its strobe
  assign push_c      = rd_sr_q[RD_LAT-1];
  assign fifo_vld_c  = (fifo_cnt_q != '0);
  assign pop_c       = fifo_vld_c && bus.I_tx_rdy;
  assign last_c      = fifo_vld_c && (sent_q == len_q - 16'd1);
  // Credit ignores a same-cycle pop so every in-flight word owns a slot
  assign credit_ok_c = ((CW+1)'(inflight_q) + (CW+1)'(fifo_cnt_q)) < (CW+1)'(FIFO_DEPTH);

  always_ff @(posedge I_PXIE_CLK or negedge I_Rst_n) begin
    if (!I_Rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    accept_c  = 1'b0;
    issue_c   = 1'b0;
    hdr_vld_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.I_c2h_en) begin
          accept_c = 1'b1;
          if (bus.I_c2h_len == '0) state_d = ST_DONE;
`ifdef PXIE_C2H_HEADER_EN
          else                     state_d = ST_HDR;
`else
          else                     state_d = ST_READ;
`endif
        end
      end
`ifdef PXIE_C2H_HEADER_EN
      ST_HDR: begin
        hdr_vld_c = 1'b1;
        if (bus.I_tx_rdy) state_d = ST_READ;
      end
`endif
      ST_READ: begin
        issue_c = (rem_q != '0) && !bus.I_sys_wren && credit_ok_c;
        if (issue_c && (rem_q == 16'd1)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pop_c && last_c) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Transfer counters and credit bookkeeping
  always_ff @(posedge I_PXIE_CLK or negedge I_Rst_n) begin
    if (!I_Rst_n) begin
      cur_addr_q <= '0;
      rem_q      <= '0;
      len_q      <= '0;
      sent_q     <= '0;
      inflight_q <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_sr_q    <= '0;
    end else begin
      if (accept_c) begin
        cur_addr_q <= bus.I_c2h_addr;
        rem_q      <= bus.I_c2h_len;
        len_q      <= bus.I_c2h_len;
        sent_q     <= '0;
      end else begin
        if (issue_c) begin
          cur_addr_q <= cur_addr_q + 16'd1;
          rem_q      <= rem_q - 16'd1;
        end
        if (pop_c) sent_q <= sent_q + 16'd1;
      end
      inflight_q <= inflight_q + CW'(issue_c) - CW'(push_c);
      fifo_cnt_q <= fifo_cnt_q + CW'(push_c) - CW'(pop_c);
      if (push_c) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PW'(1);
      rd_sr_q[0] <= issue_c;
      for (int i = 1; i < int'(RD_LAT); i++) rd_sr_q[i] <= rd_sr_q[i-1];
    end
  end

  always_ff @(posedge I_PXIE_CLK) begin
    if (push_c) mem[wr_ptr_q] <= bus.I_ram_rdata;
  end

  assign bus.O_ram_rden = issue_c;
  assign bus.O_ram_addr = cur_addr_q;
  assign bus.O_tx_vld   = hdr_vld_c | fifo_vld_c;
  assign bus.O_tx_last  = last_c;
  assign bus.O_busy     = (state_q != ST_IDLE);
  assign bus.O_done     = (state_q == ST_DONE);
  assign bus.O_c2h_drop = bus.I_c2h_en && (state_q != ST_IDLE);

`ifdef PXIE_C2H_HEADER_EN
  logic [AW-1:0] start_addr_q;
  logic [DW-1:0] hdr_word;

  always_ff @(posedge I_PXIE_CLK or negedge I_Rst_n) begin
    if (!I_Rst_n)      start_addr_q <= '0;
    else if (accept_c) start_addr_q <= bus.I_c2h_addr;
  end

  assign hdr_word      = {64'h0, 16'heb9c, 16'h1010, len_q, start_addr_q};
  assign bus.O_tx_data = hdr_vld_c ? hdr_word : (fifo_vld_c ? mem[rd_ptr_q] : '0);
`else
  assign bus.O_tx_data = fifo_vld_c ? mem[rd_ptr_q] : '0;
`endif

endmodule

// File: tb/tb_pxie_c2h_rd_sched.sv
// Directed self-checking bench for pxie_c2h_rd_sched (RD_LAT=2, FIFO_DEPTH=4).
// The RAM model returns the zero-extended word address as data.
module tb_pxie_c2h_rd_sched;
  localparam int unsigned RD_LAT     = 2;
  localparam int unsigned FIFO_DEPTH = 4;
`ifdef PXIE_C2H_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   errs  = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pxie_c2h_rd_sched_if bus();

  pxie_c2h_rd_sched #(.RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .I_PXIE_CLK (clk),
    .I_Rst_n    (rst_n),
    .bus        (bus)
  );

  // RAM model: data for the address strobed in cycle c appears in cycle c+RD_LAT
  logic [15:0] ram_p [RD_LAT];
  always @(posedge clk) begin
    ram_p[0] <= bus.O_ram_addr;
    for (int i = 1; i < int'(RD_LAT); i++) ram_p[i] <= ram_p[i-1];
  end
  assign bus.I_ram_rdata = 128'(ram_p[RD_LAT-1]);

  logic [127:0] beats [$];
  logic         lasts [$];
  int           bcyc  [$];
  logic [15:0]  raddr [$];
  int           rcyc  [$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n) begin
      if (bus.O_tx_vld && bus.I_tx_rdy) begin
        beats.push_back(bus.O_tx_data);
        lasts.push_back(bus.O_tx_last);
        bcyc.push_back(cyc);
      end
      if (bus.O_ram_rden) begin
        raddr.push_back(bus.O_ram_addr);
        rcyc.push_back(cyc);
      end
    end
  end

  function automatic logic [127:0] word(input logic [15:0] a);
    return 128'(a);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    beats.delete(); lasts.delete(); bcyc.delete(); raddr.delete(); rcyc.delete();
  endtask

  // Drives one request and collects per-cycle observations until O_done
  task automatic run_xfer(input logic [15:0] a, input logic [15:0] l, input int rdy_mode,
                          input int wren_at, input int wren_n, input int drop_at, input int budget,
                          output int en_cyc, output int done_cyc, output int max_out,
                          output int unstable, output int wren_rd, output int drop_n,
                          output int drop_cyc);
    int outst;
    logic pv, pr;
    logic [127:0] pd;
    clear_logs();
    outst = 0; max_out = 0; unstable = 0; wren_rd = 0; drop_n = 0; drop_cyc = -1; done_cyc = -1;
    pv = 1'b0; pr = 1'b0; pd = '0;
    tick();
    bus.I_c2h_addr = a; bus.I_c2h_len = l; bus.I_c2h_en = 1'b1;
    bus.I_sys_wren = 1'b0; bus.I_tx_rdy = 1'b1;
    en_cyc = cyc;
    for (int k = 0; k <= budget; k++) begin
      if (k > 0) begin
        tick();
        bus.I_c2h_en = (k == drop_at);
        if (k == drop_at) begin bus.I_c2h_addr = 16'h1234; bus.I_c2h_len = 16'd5; end
        bus.I_tx_rdy   = (rdy_mode == 0) ? 1'b1 : ((k % 2) == 1);
        bus.I_sys_wren = (k >= wren_at) && (k < wren_at + wren_n);
      end
      #1;
      if (pv && !pr && !(bus.O_tx_vld && (bus.O_tx_data == pd))) unstable++;
      if (bus.I_sys_wren && bus.O_ram_rden) wren_rd++;
      if (bus.O_c2h_drop) begin drop_n++; drop_cyc = k; end
      outst += int'(bus.O_ram_rden) - int'(bus.O_tx_vld && bus.I_tx_rdy);
      if (outst > max_out) max_out = outst;
      pv = bus.O_tx_vld; pr = bus.I_tx_rdy; pd = bus.O_tx_data;
      if (bus.O_done) begin done_cyc = cyc; break; end
    end
    bus.I_c2h_en = 1'b0; bus.I_sys_wren = 1'b0;
  endtask

  task automatic test_reset();
    bus.I_c2h_addr = '0; bus.I_c2h_len = '0; bus.I_c2h_en = 1'b0;
    bus.I_sys_wren = 1'b0; bus.I_tx_rdy = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if ({bus.O_ram_rden, bus.O_tx_vld, bus.O_tx_last, bus.O_busy, bus.O_done, bus.O_c2h_drop} !== 6'b0) begin
      errs++;
      $display("FAIL reset_flags: got %b want 000000", {bus.O_ram_rden, bus.O_tx_vld, bus.O_tx_last,
               bus.O_busy, bus.O_done, bus.O_c2h_drop});
    end
    checks++;
    if (bus.O_ram_addr !== 16'h0) begin errs++; $display("FAIL reset_addr: got %h want 0000", bus.O_ram_addr); end
    checks++;
    if (bus.O_tx_data !== 128'h0) begin errs++; $display("FAIL reset_data: got %h want 0", bus.O_tx_data); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic check_data(input string nm, input logic [15:0] a, input int n);
    checks++;
    if (beats.size() != n + HDR) begin
      errs++; $display("FAIL %s_beat_count: got %0d want %0d", nm, beats.size(), n + HDR);
    end else begin
      for (int j = 0; j < n; j++) begin
        checks++;
        if (beats[j+HDR] !== word(a + 16'(j))) begin
          errs++; $display("FAIL %s_data[%0d]: got %h want %h", nm, j, beats[j+HDR], word(a + 16'(j)));
        end
        checks++;
        if (lasts[j+HDR] !== (j == n - 1)) begin
          errs++; $display("FAIL %s_last[%0d]: got %b want %b", nm, j, lasts[j+HDR], (j == n - 1));
        end
      end
    end
  endtask

  task automatic test_basic();
    int en_c, dn_c, mo, us, wr, dn, dc;
    run_xfer(16'h0010, 16'd4, 0, -1, 0, -1, 60, en_c, dn_c, mo, us, wr, dn, dc);
    checks++;
    if (dn_c < 0) begin errs++; $display("FAIL basic_done: no O_done within budget"); end
    check_data("basic", 16'h0010, 4);
    if (beats.size() == 4 + HDR) begin
      checks++;
      if (bcyc[HDR] - en_c != int'(RD_LAT) + 2 + HDR) begin
        errs++; $display("FAIL basic_latency: got %0d want %0d", bcyc[HDR] - en_c, int'(RD_LAT) + 2 + HDR);
      end
      checks++;
      if (bcyc[3+HDR] - bcyc[HDR] != 3) begin
        errs++; $display("FAIL basic_throughput: span %0d want 3", bcyc[3+HDR] - bcyc[HDR]);
      end
      checks++;
      if (dn_c != bcyc[3+HDR] + 1) begin
        errs++; $display("FAIL basic_done_timing: got %0d want %0d", dn_c, bcyc[3+HDR] + 1);
      end
    end
    checks++;
    if (rcyc.size() == 0 || rcyc[0] - en_c != 1 + HDR) begin
      errs++; $display("FAIL basic_first_read: got %0d want %0d", (rcyc.size() == 0) ? -1 : rcyc[0] - en_c, 1 + HDR);
    end
    tick(); #1;
    checks++;
    if ({bus.O_done, bus.O_busy} !== 2'b00) begin
      errs++; $display("FAIL basic_done_pulse: done/busy got %b want 00", {bus.O_done, bus.O_busy});
    end
  endtask

  task automatic test_backpressure();
    int en_c, dn_c, mo, us, wr, dn, dc;
    run_xfer(16'h0200, 16'd8, 1, -1, 0, -1, 120, en_c, dn_c, mo, us, wr, dn, dc);
    checks++;
    if (dn_c < 0) begin errs++; $display("FAIL bp_done: no O_done within budget"); end
    check_data("bp", 16'h0200, 8);
    checks++;
    if (mo > int'(FIFO_DEPTH)) begin errs++; $display("FAIL bp_outstanding: got %0d want <= %0d", mo, FIFO_DEPTH); end
    checks++;
    if (us != 0) begin errs++; $display("FAIL bp_stable: %0d unstable stalls, want 0", us); end
  endtask

  task automatic test_write_priority();
    int en_c, dn_c, mo, us, wr, dn, dc;
    run_xfer(16'h0300, 16'd6, 0, 2 + HDR, 3, -1, 80, en_c, dn_c, mo, us, wr, dn, dc);
    checks++;
    if (wr != 0) begin errs++; $display("FAIL wp_read_during_write: got %0d want 0", wr); end
    checks++;
    if (raddr.size() != 6) begin
      errs++; $display("FAIL wp_read_count: got %0d want 6", raddr.size());
    end else begin
      for (int j = 0; j < 6; j++) begin
        checks++;
        if (raddr[j] !== 16'h0300 + 16'(j)) begin
          errs++; $display("FAIL wp_addr[%0d]: got %h want %h", j, raddr[j], 16'h0300 + 16'(j));
        end
      end
      checks++;
      if (rcyc[1] - en_c != 5 + HDR) begin
        errs++; $display("FAIL wp_resume: got %0d want %0d", rcyc[1] - en_c, 5 + HDR);
      end
    end
    check_data("wp", 16'h0300, 6);
  endtask

  task automatic test_wrap_drop();
    int en_c, dn_c, mo, us, wr, dn, dc;
    logic [15:0] exp_a [3];
    exp_a[0] = 16'hFFFE; exp_a[1] = 16'hFFFF; exp_a[2] = 16'h0000;
    run_xfer(16'hFFFE, 16'd3, 0, -1, 0, 2, 60, en_c, dn_c, mo, us, wr, dn, dc);
    checks++;
    if (raddr.size() != 3) begin
      errs++; $display("FAIL wrap_read_count: got %0d want 3", raddr.size());
    end else begin
      for (int j = 0; j < 3; j++) begin
        checks++;
        if (raddr[j] !== exp_a[j]) begin
          errs++; $display("FAIL wrap_addr[%0d]: got %h want %h", j, raddr[j], exp_a[j]);
        end
      end
    end
    checks++;
    if (dn != 1 || dc != 2) begin
      errs++; $display("FAIL drop_pulse: got %0d pulses at k=%0d want 1 at k=2", dn, dc);
    end
    check_data("wrap", 16'hFFFE, 3);
    checks++;
    if (dn_c < 0) begin errs++; $display("FAIL wrap_done: no O_done within budget"); end
  endtask

  task automatic test_len_zero();
    int en_c, dn_c, mo, us, wr, dn, dc;
    run_xfer(16'h0400, 16'd0, 0, -1, 0, -1, 20, en_c, dn_c, mo, us, wr, dn, dc);
    checks++;
    if (dn_c - en_c != 1) begin errs++; $display("FAIL zero_done: got %0d want 1", dn_c - en_c); end
    checks++;
    if (beats.size() != 0 || raddr.size() != 0) begin
      errs++; $display("FAIL zero_activity: beats %0d reads %0d want 0 0", beats.size(), raddr.size());
    end
    tick(); #1;
    checks++;
    if ({bus.O_done, bus.O_busy} !== 2'b00) begin
      errs++; $display("FAIL zero_idle: done/busy got %b want 00", {bus.O_done, bus.O_busy});
    end
  endtask

  task automatic test_reset_mid();
    int stale;
    clear_logs();
    tick();
    bus.I_c2h_addr = 16'h0500; bus.I_c2h_len = 16'd8; bus.I_c2h_en = 1'b1; bus.I_tx_rdy = 1'b0;
    for (int k = 0; k < 6; k++) begin tick(); bus.I_c2h_en = 1'b0; end
    #1;
    checks++;
    if (bus.O_tx_vld !== 1'b1) begin errs++; $display("FAIL rstmid_prefill: vld got %b want 1", bus.O_tx_vld); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.O_ram_rden, bus.O_tx_vld, bus.O_tx_last, bus.O_busy, bus.O_done, bus.O_c2h_drop} !== 6'b0
        || bus.O_tx_data !== 128'h0 || bus.O_ram_addr !== 16'h0) begin
      errs++; $display("FAIL rstmid_outputs: flags %b addr %h data %h want all zero",
               {bus.O_ram_rden, bus.O_tx_vld, bus.O_tx_last, bus.O_busy, bus.O_done, bus.O_c2h_drop},
               bus.O_ram_addr, bus.O_tx_data);
    end
    tick(); tick();
    rst_n = 1'b1;
    bus.I_tx_rdy = 1'b1;
    clear_logs();
    stale = 0;
    for (int k = 0; k < 10; k++) begin
      tick(); #1;
      if (bus.O_tx_vld || bus.O_busy || bus.O_done) stale++;
    end
    checks++;
    if (stale != 0) begin errs++; $display("FAIL rstmid_stale_cycles: got %0d want 0", stale); end
    checks++;
    if (beats.size() != 0 || raddr.size() != 0) begin
      errs++; $display("FAIL rstmid_stale_beats: beats %0d reads %0d want 0 0", beats.size(), raddr.size());
    end
  endtask

`ifdef PXIE_C2H_HEADER_EN
  task automatic test_header();
    int en_c, dn_c, mo, us, wr, dn, dc;
    logic [127:0] exp_h;
    exp_h = {64'h0, 16'heb9c, 16'h1010, 16'h0002, 16'h0100};
    run_xfer(16'h0100, 16'd2, 0, -1, 0, -1, 40, en_c, dn_c, mo, us, wr, dn, dc);
    check_data("hdr", 16'h0100, 2);
    if (beats.size() == 3) begin
      checks++;
      if (beats[0] !== exp_h || lasts[0] !== 1'b0) begin
        errs++; $display("FAIL hdr_beat: got %h last %b want %h last 0", beats[0], lasts[0], exp_h);
      end
      checks++;
      if (rcyc.size() == 0 || rcyc[0] <= bcyc[0]) begin
        errs++; $display("FAIL hdr_order: first read before header handshake");
      end
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_write_priority();
    test_wrap_drop();
    test_len_zero();
`ifdef PXIE_C2H_HEADER_EN
    test_header();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
